spi_master: RTL and testbench
=============================

# spi_master

SPI master controller: the stage directly upstream of the team's SPI slave. It generates SCLK, CS and MOSI and captures MISO, for one 8-bit full-duplex transfer per start request. Clock polarity and phase are run-time inputs, so the master can exercise all four SPI modes against the slave.

## Interface
Parameters:
- CLK_DIV, 4: system clk cycles per SCLK half-period. Legal values are 2..255; the slave oversamples SCLK, so values below 2 are illegal.

Ports:
- clk  input  1  system clock; all logic is on its rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  transfer request, sampled only while busy=0.
- tx_data  input  8  byte to send; latched on the accepted start cycle.
- CPOL  input  1  idle level of SCLK; latched on the accepted start.
- CPHA  input  1  0 = sample on leading edge, 1 = sample on trailing edge; latched on the accepted start.
- MISO  input  1  serial data from the slave.
- SCLK  output  1  SPI clock (registered).
- CS  output  1  active-low chip select (registered).
- MOSI  output  1  serial data to the slave (registered).
- busy  output  1  high from the cycle after an accepted start until the end of the GAP state.
- done  output  1  one-cycle pulse, coincident with CS rising.
- rx_data  output  8  received byte; updated when done pulses and held until the next done.

## Operation
- Reset values: CS=1, SCLK=0, MOSI=0, busy=0, done=0, rx_data=0x00; FSM in IDLE; all counters 0.
- FSM states and transitions:
  - IDLE: SCLK is driven from the CPOL input every cycle. On start=1, latch tx_data into the shift register, latch CPOL and CPHA, and go to SETUP.
  - SETUP: CS=0, SCLK=latched CPOL, busy=1. If CPHA=0, MOSI=tx bit 7. Lasts CLK_DIV cycles, then go to TRANSFER.
  - TRANSFER: SCLK toggles every CLK_DIV cycles, for 16 edges total. Edge 1 is the leading edge; edges alternate leading/trailing.
    - CPHA=0: sample MISO into rx_shift on leading edges; shift out the next MOSI bit on trailing edges, except edge 16.
    - CPHA=1: drive the next MOSI bit on leading edges; sample MISO on trailing edges.
    - After edge 16, go to HOLD.
  - HOLD: SCLK=CPOL and CS=0 for CLK_DIV cycles. Then CS goes to 1, rx_data is loaded from rx_shift, done pulses, and the FSM goes to GAP.
  - GAP: CS=1, busy=1 for CLK_DIV cycles. This guarantees the minimum CS-high time the slave needs to return to its idle state. Then go to IDLE.
- Bit order is MSB-first. The divider counter is 8 bits and the edge counter is 5 bits; both clear on every state entry.
- Boundary conditions:
  - start while busy=1 is ignored; no queueing.
  - Changes to tx_data, CPOL or CPHA during a transfer have no effect.
  - reset asserted in any state returns all outputs to their reset values on the next clk edge, with no done pulse. CS rises on that edge, which aborts the transfer at the slave.
  - start held high continuously produces back-to-back transfers, each separated by the GAP time.

## Timing
- Let S be the cycle in which start is accepted.
  - CS falls at S+1.
  - SCLK edge k (k = 1..16) occurs at S+1+k·CLK_DIV.
  - CS rises and done pulses at S+1+18·CLK_DIV.
  - busy falls at S+1+19·CLK_DIV.
  - The earliest next accepted start is S+1+19·CLK_DIV.
- With CLK_DIV=4: CS falls at S+1, the first edge is at S+5, done is at S+73, and busy falls at S+77.
- MISO is sampled from the clk edge that updates SCLK, using the MISO value present in that cycle.
- MOSI changes in the same cycle as the corresponding shift edge.

## Configuration
- SPI_MASTER_LSB_FIRST_EN
  - Defined: transmit tx_data bit 0 first, and assemble rx_data so that the first received bit lands in bit 0.
  - Undefined (default): MSB-first on both directions, matching the slave.
  - Timing is identical in both cases.

## Test plan
- Mode 0, CLK_DIV=4, tx_data=0xA5, MISO looped to MOSI -> rx_data=0xA5; done at S+73; exactly 16 SCLK edges; SCLK idles low.
- Mode 3, against the slave RTL with slave data_in=0x3C, tx_data=0xC3 -> master rx_data=0x3C; slave data_out=0xC3; SCLK idles high before and after the transfer.
- Modes 1 and 2 against the slave with slave data_in=0x81 and tx_data=0x7E -> both bytes exchanged correctly; MOSI stable at every sampling edge.
- start pulsed again at S+10 with tx_data=0xFF during a 0x12 transfer -> ignored; exactly one done; slave receives 0x12.
- reset asserted at S+30 -> next cycle CS=1, SCLK=0, busy=0, rx_data=0x00; no done pulse; a new start afterwards completes normally.
- With SPI_MASTER_LSB_FIRST_EN defined, tx_data=0x01 in loopback -> MOSI is high only during the first bit; rx_data=0x01.

Source files
------------

// File: rtl/spi_master.sv
// SPI master: one 8-bit full-duplex transfer per start, CPOL/CPHA selectable at run time.
// Define SPI_MASTER_LSB_FIRST_EN to shift LSB-first in both directions (default MSB-first).
module spi_master #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] tx_data,
  input  logic       CPOL,
  input  logic       CPHA,
  input  logic       MISO,
  output logic       SCLK,
  output logic       CS,
  output logic       MOSI,
  output logic       busy,
  output logic       done,
  output logic [7:0] rx_data
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_TRANSFER,
    ST_HOLD,
    ST_GAP
  } state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  state_t     state_q, state_d;
  logic [7:0] div_q, div_d;
  logic [4:0] edge_q, edge_d;
  logic [7:0] tx_shift_q, tx_shift_d;
  logic [7:0] rx_shift_q, rx_shift_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       cpol_q, cpol_d;
  logic       cpha_q, cpha_d;
  logic       sclk_q, sclk_d;
  logic       cs_q, cs_d;
  logic       mosi_q, mosi_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  logic       period_end;
  logic       do_edge;
  logic [4:0] edge_num;
  logic       sample_edge;
  logic       tx_bit;
  logic [7:0] tx_shifted;
  logic [7:0] rx_shifted;
  logic       first_bit;
  logic [7:0] tx_load_shifted;

`ifdef SPI_MASTER_LSB_FIRST_EN
  assign tx_bit          = tx_shift_q[0];
  assign tx_shifted      = {1'b0, tx_shift_q[7:1]};
  assign rx_shifted      = {MISO, rx_shift_q[7:1]};
  assign first_bit       = tx_data[0];
  assign tx_load_shifted = {1'b0, tx_data[7:1]};
`else
  assign tx_bit          = tx_shift_q[7];
  assign tx_shifted      = {tx_shift_q[6:0], 1'b0};
  assign rx_shifted      = {rx_shift_q[6:0], MISO};
  assign first_bit       = tx_data[7];
  assign tx_load_shifted = {tx_data[6:0], 1'b0};
`endif

  assign period_end = (div_q == DIV_LAST);
  // Edge 1 is produced on the SETUP->TRANSFER step; edge_q counts completed half-periods in TRANSFER.
  assign edge_num    = (state_q == ST_SETUP) ? 5'd1 : (edge_q + 5'd2);
  assign sample_edge = (edge_num[0] != cpha_q);

  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    edge_d     = edge_q;
    tx_shift_d = tx_shift_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    cpol_d     = cpol_q;
    cpha_d     = cpha_q;
    sclk_d     = sclk_q;
    cs_d       = cs_q;
    mosi_d     = mosi_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    do_edge    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        sclk_d = CPOL;
        div_d  = 8'd0;
        edge_d = 5'd0;
        if (start) begin
          cpol_d     = CPOL;
          cpha_d     = CPHA;
          cs_d       = 1'b0;
          busy_d     = 1'b1;
          rx_shift_d = 8'h00;
          if (!CPHA) begin
            mosi_d     = first_bit;
            tx_shift_d = tx_load_shifted;
          end else begin
            mosi_d     = 1'b0;
            tx_shift_d = tx_data;
          end
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        sclk_d = cpol_q;
        div_d  = div_q + 8'd1;
        if (period_end) begin
          div_d   = 8'd0;
          edge_d  = 5'd0;
          do_edge = 1'b1;
          state_d = ST_TRANSFER;
        end
      end
      ST_TRANSFER: begin
        div_d = div_q + 8'd1;
        if (period_end) begin
          div_d = 8'd0;
          if (edge_q == 5'd15) begin
            edge_d  = 5'd0;
            state_d = ST_HOLD;
          end else begin
            edge_d  = edge_q + 5'd1;
            do_edge = 1'b1;
          end
        end
      end
      ST_HOLD: begin
        sclk_d = cpol_q;
        div_d  = div_q + 8'd1;
        if (period_end) begin
          div_d     = 8'd0;
          cs_d      = 1'b1;
          done_d    = 1'b1;
          rx_data_d = rx_shift_q;
          state_d   = ST_GAP;
        end
      end
      ST_GAP: begin
        div_d = div_q + 8'd1;
        if (period_end) begin
          div_d   = 8'd0;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (do_edge) begin
      sclk_d = ~sclk_q;
      if (sample_edge) begin
        rx_shift_d = rx_shifted;
      end else if (edge_num != 5'd16) begin
        mosi_d     = tx_bit;
        tx_shift_d = tx_shifted;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      div_q      <= 8'd0;
      edge_q     <= 5'd0;
      tx_shift_q <= 8'h00;
      rx_shift_q <= 8'h00;
      rx_data_q  <= 8'h00;
      cpol_q     <= 1'b0;
      cpha_q     <= 1'b0;
      sclk_q     <= 1'b0;
      cs_q       <= 1'b1;
      mosi_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      edge_q     <= edge_d;
      tx_shift_q <= tx_shift_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      cpol_q     <= cpol_d;
      cpha_q     <= cpha_d;
      sclk_q     <= sclk_d;
      cs_q       <= cs_d;
      mosi_q     <= mosi_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign SCLK    = sclk_q;
  assign CS      = cs_q;
  assign MOSI    = mosi_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign rx_data = rx_data_q;

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: a behavioural SPI slave watches SCLK/CS and checks timing, data and aborts.
`timescale 1ns/1ps
module tb_spi_master;
  localparam int D = 4;

  logic       clk;
  logic       reset;
  logic       start;
  logic [7:0] tx_data;
  logic       cpol;
  logic       cpha;
  logic       miso_w;
  logic       sclk;
  logic       cs;
  logic       mosi;
  logic       busy;
  logic       done;
  logic [7:0] rx_data;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural slave / monitor state
  int         cyc;
  int         xfer_s;
  logic       mode_cpol, mode_cpha;
  bit         loopback;
  logic [7:0] slave_tx;
  logic [7:0] slave_rx;
  logic       miso_slave;
  int         s_tx_idx, s_rx_idx;
  int         n_edges, edge_ok_cnt, first_edge_ok, mosi_unstable, mosi_high_cnt;
  int         cs_fall_cyc, done_cyc, busy_fall_cyc, done_cnt;
  logic       prev_cs, prev_sclk, prev_mosi, prev_busy;

  assign miso_w = loopback ? mosi : miso_slave;

  spi_master #(.CLK_DIV(D)) dut (
    .clk(clk), .reset(reset), .start(start), .tx_data(tx_data),
    .CPOL(cpol), .CPHA(cpha), .MISO(miso_w),
    .SCLK(sclk), .CS(cs), .MOSI(mosi), .busy(busy), .done(done), .rx_data(rx_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // i-th bit on the wire of byte b
  function automatic logic order_bit(input logic [7:0] b, input int i);
`ifdef SPI_MASTER_LSB_FIRST_EN
    return b[i];
`else
    return b[7-i];
`endif
  endfunction

  function automatic logic [7:0] place_bit(input logic [7:0] b, input int i, input logic v);
    logic [7:0] r;
    r = b;
`ifdef SPI_MASTER_LSB_FIRST_EN
    r[i] = v;
`else
    r[7-i] = v;
`endif
    return r;
  endfunction

  initial begin
    cyc = 0; done_cnt = 0; n_edges = 0; edge_ok_cnt = 0; first_edge_ok = 0;
    mosi_unstable = 0; mosi_high_cnt = 0; s_tx_idx = 0; s_rx_idx = 0;
    cs_fall_cyc = -1; done_cyc = -1; busy_fall_cyc = -1; xfer_s = 0;
    prev_cs = 1'b1; prev_sclk = 1'b0; prev_mosi = 1'b0; prev_busy = 1'b0;
    slave_rx = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (prev_cs === 1'b1 && cs === 1'b0) begin
        cs_fall_cyc = cyc; n_edges = 0; edge_ok_cnt = 0; first_edge_ok = 0;
        s_tx_idx = 0; s_rx_idx = 0; slave_rx = 8'h00; mosi_unstable = 0; mosi_high_cnt = 0;
        if (!mode_cpha) begin
          miso_slave = order_bit(slave_tx, 0);
          s_tx_idx = 1;
        end
      end else if (cs === 1'b0 && sclk !== prev_sclk) begin
        n_edges++;
        if (cyc == xfer_s + 1 + n_edges * D) edge_ok_cnt++;
        if (n_edges == 1 && sclk === ~mode_cpol) first_edge_ok = 1;
        if (((n_edges % 2) == 1) != (mode_cpha == 1'b1)) begin
          if (mosi !== prev_mosi) mosi_unstable++;
          if (s_rx_idx < 8) begin
            slave_rx = place_bit(slave_rx, s_rx_idx, mosi);
            s_rx_idx++;
          end
        end else if (s_tx_idx < 8) begin
          miso_slave = order_bit(slave_tx, s_tx_idx);
          s_tx_idx++;
        end
      end
      if (cs === 1'b0 && mosi === 1'b1) mosi_high_cnt++;
      if (done === 1'b1) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (prev_busy === 1'b1 && busy === 1'b0) busy_fall_cyc = cyc;
      prev_cs = cs; prev_sclk = sclk; prev_mosi = mosi; prev_busy = busy;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, observed time %0t required < 1ms", $time);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200 && busy !== 1'b0; i++) @(negedge clk);
  endtask

  task automatic launch(input logic [7:0] tx, input logic [7:0] sd, input logic pol,
                        input logic pha, input bit loop, output int s);
    mode_cpol = pol; mode_cpha = pha; slave_tx = sd; loopback = loop;
    cs_fall_cyc = -1; done_cyc = -1; busy_fall_cyc = -1; n_edges = 0; edge_ok_cnt = 0;
    cpol = pol; cpha = pha; tx_data = tx; start = 1'b1;
    s = cyc; xfer_s = cyc;
  endtask

  task automatic do_xfer(input logic [7:0] tx, input logic [7:0] sd, input logic pol,
                         input logic pha, input bit loop, input bit poke);
    int s;
    int d0;
    @(negedge clk);
    wait_idle();
    d0 = done_cnt;
    launch(tx, sd, pol, pha, loop, s);
    @(negedge clk);
    start = 1'b0; tx_data = 8'($urandom); cpha = 1'($urandom); cpol = 1'($urandom);
    if (poke) begin
      while (cyc < s + 10) @(negedge clk);
      start = 1'b1; tx_data = 8'hFF;
      @(negedge clk);
      start = 1'b0;
    end
    for (int i = 0; i < 400 && done_cnt == d0; i++) @(negedge clk);
    cpol = pol;
    for (int i = 0; i < 100 && busy !== 1'b0; i++) @(negedge clk);
    @(negedge clk);
    chk("cs_fall_cycle", cs_fall_cyc, s + 1);
    chk("sclk_edge_count", n_edges, 16);
    chk("sclk_edge_timing", edge_ok_cnt, 16);
    chk("first_edge_direction", first_edge_ok, 1);
    chk("done_cycle", done_cyc, s + 1 + 18 * D);
    chk("done_count", done_cnt - d0, 1);
    chk("busy_fall_cycle", busy_fall_cyc, s + 1 + 19 * D);
    chk("master_rx_data", rx_data, loop ? tx : sd);
    chk("slave_rx_data", slave_rx, tx);
    chk("mosi_stable_at_sample", mosi_unstable, 0);
    chk("sclk_idle_level", sclk, pol);
  endtask

  initial begin
    int s;
    int d0;
    logic [7:0] one_hot_first;
    reset = 1'b1; start = 1'b0; tx_data = 8'h00; cpol = 1'b0; cpha = 1'b0;
    loopback = 1'b0; miso_slave = 1'b0; mode_cpol = 1'b0; mode_cpha = 1'b0; slave_tx = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset_cs", cs, 1'b1);
    chk("reset_sclk", sclk, 1'b0);
    chk("reset_mosi", mosi, 1'b0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", done, 1'b0);
    chk("reset_rx_data", rx_data, 8'h00);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Mode 0 loopback, then all modes against the slave model
    do_xfer(8'hA5, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    do_xfer(8'hC3, 8'h3C, 1'b1, 1'b1, 1'b0, 1'b0);
    do_xfer(8'h7E, 8'h81, 1'b0, 1'b1, 1'b0, 1'b0);
    do_xfer(8'h7E, 8'h81, 1'b1, 1'b0, 1'b0, 1'b0);

    // Start during busy is ignored
    do_xfer(8'h12, 8'h5D, 1'b0, 1'b0, 1'b0, 1'b1);

    for (int k = 0; k < 8; k++)
      do_xfer(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'b0);

    // Only the first wire bit set: MOSI high for exactly that first bit
`ifdef SPI_MASTER_LSB_FIRST_EN
    one_hot_first = 8'h01;
`else
    one_hot_first = 8'h80;
`endif
    do_xfer(one_hot_first, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("first_bit_mosi_high_cycles", mosi_high_cnt, 2 * D);

    // Reset mid-transfer aborts without a done pulse
    @(negedge clk);
    wait_idle();
    d0 = done_cnt;
    launch(8'h5A, 8'h99, 1'b1, 1'b1, 1'b0, s);
    @(negedge clk);
    start = 1'b0;
    while (cyc < s + 30) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_cs", cs, 1'b1);
    chk("abort_sclk", sclk, 1'b0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_rx_data", rx_data, 8'h00);
    chk("abort_done", done, 1'b0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_no_done", done_cnt - d0, 0);
    do_xfer(8'h6B, 8'hD2, 1'b0, 1'b0, 1'b0, 1'b0);

    // start held high: second transfer begins right after the gap
    @(negedge clk);
    wait_idle();
    d0 = done_cnt;
    launch(8'h3E, 8'hE3, 1'b0, 1'b1, 1'b0, s);
    for (int i = 0; i < 400 && done_cnt == d0; i++) @(negedge clk);
    chk("b2b_first_rx", rx_data, 8'hE3);
    xfer_s = s + 1 + 19 * D;
    while (cyc < xfer_s + 1) @(negedge clk);
    start = 1'b0;
    chk("b2b_second_cs_fall", cs_fall_cyc, xfer_s + 1);
    for (int i = 0; i < 400 && done_cnt == d0 + 1; i++) @(negedge clk);
    chk("b2b_done_count", done_cnt - d0, 2);
    chk("b2b_second_done_cycle", done_cyc, xfer_s + 1 + 18 * D);
    chk("b2b_second_rx", rx_data, 8'hE3);
    chk("b2b_second_slave_rx", slave_rx, 8'h3E);
    repeat (2 * D) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
